// File: rtl/cgra_config_loader.sv
// Drives the serial CGRA configurator and deserializes its bitstream into one
// parallel configuration word, committed only after a clean done handshake.
module cgra_config_loader #(
  parameter int TOTAL_NUM_BITS = 285,
  parameter int DONE_TIMEOUT   = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      hold,
  input  logic                      cfg_bitstream,
  input  logic                      cfg_done,
  output logic                      cfg_enable,
  output logic                      cfg_sync_reset,
  output logic [TOTAL_NUM_BITS-1:0] config_word,
  output logic                      config_valid,
  output logic                      busy,
  output logic                      error
);

  localparam int CW = $clog2(TOTAL_NUM_BITS + 1);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CW-1:0] NBITS = CW'(TOTAL_NUM_BITS);
  localparam logic [CW-1:0] LAST  = CW'(TOTAL_NUM_BITS - 1);
  localparam logic [TW-1:0] TLAST = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RESTART,
    SHIFT,
    WAIT_DONE,
    FAULT
  } state_t;

  state_t                    state;
  state_t                    next_state;
  logic [CW-1:0]             issued;
  logic [CW-1:0]             received;
  logic [TW-1:0]             wait_cnt;
  logic [TOTAL_NUM_BITS-1:0] sr;
  logic                      en_q;
  logic                      launch;
  logic                      capture;
  logic                      commit;

  // Bits arrive one cycle after the enable that requested them, so capture follows en_q.
  always_comb begin
    next_state     = state;
    cfg_enable     = 1'b0;
    cfg_sync_reset = 1'b0;
    busy           = 1'b0;
    launch         = 1'b0;
    capture        = 1'b0;
    commit         = 1'b0;
    case (state)
      IDLE, FAULT: begin
        if (start) begin
          launch     = 1'b1;
          next_state = RESTART;
        end
      end
      RESTART: begin
        busy           = 1'b1;
        cfg_sync_reset = 1'b1;
        next_state     = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        cfg_enable = (issued < NBITS) && !hold;
        capture    = en_q;
        if (cfg_done) begin
          next_state = FAULT;
        end else if (en_q && (received == LAST)) begin
          next_state = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (cfg_done) begin
          commit     = 1'b1;
          next_state = IDLE;
        end else if (wait_cnt == TLAST) begin
          next_state = FAULT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      issued       <= '0;
      received     <= '0;
      wait_cnt     <= '0;
      sr           <= '0;
      en_q         <= 1'b0;
      config_word  <= '0;
      config_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      state <= next_state;
      en_q  <= cfg_enable;
      if (launch) begin
        issued       <= '0;
        received     <= '0;
        config_valid <= 1'b0;
        error        <= 1'b0;
      end
      if (cfg_enable) begin
        issued <= issued + 1'b1;
      end
      if (capture) begin
        sr       <= {sr[TOTAL_NUM_BITS-2:0], cfg_bitstream};
        received <= received + 1'b1;
      end
      // Timeout count restarts on every entry into WAIT_DONE.
      if (state == WAIT_DONE) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (commit) begin
        config_word  <= sr;
        config_valid <= 1'b1;
      end
      if ((next_state == FAULT) && (state != FAULT)) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cgra_config_loader.md
# cgra_config_loader

Loader FSM that drives the serial CGRA configurator and deserializes its bitstream into one parallel configuration word. It sits directly downstream of the configurator. It owns the configurator's `enable` and `sync_reset`, counts the bits it receives, and checks the `done` handshake. On a clean load it presents the captured word with a `config_valid` flag to the fabric configuration ports.

## Interface
Parameters:
- `TOTAL_NUM_BITS`, 285: bitstream length; must equal the configurator's length.
- `DONE_TIMEOUT`, 16: maximum cycles spent in WAIT_DONE before an error is flagged.

Ports:
- `clock`  in  1: sole clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: load request; sampled in IDLE and ERROR, ignored otherwise.
- `hold`  in  1: backpressure; while high, no new bits are requested.
- `cfg_bitstream`  in  1: serial bit from the configurator.
- `cfg_done`  in  1: configurator `done`.
- `cfg_enable`  out  1: to configurator `enable`.
- `cfg_sync_reset`  out  1: to configurator `sync_reset`.
- `config_word`  out  TOTAL_NUM_BITS: committed configuration; bit `TOTAL_NUM_BITS-1-i` holds stream bit i.
- `config_valid`  out  1: `config_word` holds a complete, checked load.
- `busy`  out  1: high in RESTART, SHIFT, and WAIT_DONE.
- `error`  out  1: sticky until the next `start`.

## Operation
- States: IDLE, RESTART, SHIFT, WAIT_DONE, ERROR. Counters `issued` and `received` are each `$clog2(TOTAL_NUM_BITS+1)` bits wide. The timeout counter is `$clog2(DONE_TIMEOUT+1)` bits wide.
- **IDLE or ERROR, `start`=1:** go to RESTART. Clear `issued`, `received`, `config_valid` and `error`.
- **RESTART (exactly 1 cycle):**
  - `cfg_sync_reset`=1 and `cfg_enable`=0; `cfg_done` is ignored.
  - Next state: SHIFT.
- **SHIFT:**
  - `cfg_enable` = (`issued` < TOTAL_NUM_BITS) && !`hold`. It is combinational from state, counter and `hold`.
  - `issued` increments on every cycle with `cfg_enable`=1.
  - `en_q` is the registered `cfg_enable`, cleared in RESTART.
  - On each edge with `en_q`=1: shift register `sr <= {sr[N-2:0], cfg_bitstream}` and increment `received`.
  - When `received` reaches TOTAL_NUM_BITS, go to WAIT_DONE.
  - `cfg_done`=1 seen in SHIFT means a length mismatch: go to ERROR.
- **WAIT_DONE:**
  - `cfg_done`=1: on that edge, `config_word <= sr`, `config_valid <= 1`, go to IDLE.
  - After DONE_TIMEOUT cycles without `cfg_done`: go to ERROR.
- **ERROR:**
  - `error`=1 and `busy`=0.
  - `config_valid` stays 0.
  - `config_word` keeps its last committed value.
- **Captured values:** X/Z bits from the stream are captured as-is, with no checking.
- **`start` while busy:** ignored.
- **`hold` mid-stream:** a bit already requested on the previous cycle is still captured.

## Timing
- **Reset (`reset_n`=0):**
  - State IDLE.
  - Registered outputs `config_word`, `config_valid`, `error` and internal `sr`, counters and `en_q` are all 0; `busy`=0.
  - Combinational `cfg_enable`=0 and `cfg_sync_reset`=0, because they are decoded from IDLE.
  - Asserting reset mid-load aborts immediately. The configurator is realigned by the RESTART of the next load.
- **Load latency with `hold`=0:**
  - `start` sampled at edge E0; RESTART runs in the cycle after E0.
  - `cfg_enable` is high for N cycles; the configurator samples it at E2..E(N+1).
  - Bits are captured at E3..E(N+2), and the state enters WAIT_DONE at E(N+2).
  - `cfg_done` is visible after E(N+2); `config_valid` rises at E(N+3).
- **Effect of `hold`:** each held cycle during SHIFT adds exactly one cycle to the latency.
- **`config_valid`:** stays high until the next `start` or reset.
- **Timeout:** the counter starts at WAIT_DONE entry. ERROR is entered at the edge ending the DONE_TIMEOUT-th cycle without `cfg_done`.

## Test plan
- **Nominal:** TOTAL_NUM_BITS=8, configurator model storage 8'b1011_0010, pulse `start` → `config_word`=8'hB2, `config_valid` rises 11 edges after the `start` edge, `error`=0.
- **Backpressure:** same stream, `hold`=1 for 3 cycles mid-SHIFT → same word, valid 3 cycles later, exactly 8 `cfg_enable` cycles.
- **Length mismatch:**
  - Model length 6 with loader length 8 → `cfg_done` seen in SHIFT.
  - Required: `error`=1, `config_valid`=0, previous `config_word` retained.
- **Timeout:** model never raises `cfg_done`, DONE_TIMEOUT=4 → ERROR exactly 4 cycles after WAIT_DONE entry. A following `start` clears `error` and reloads correctly.
- **Reset mid-load:** `reset_n` low after 5 bits → all outputs 0 asynchronously. Next `start` gives a full correct load, with `cfg_sync_reset` pulsed for 1 cycle.
- **Full size:** TOTAL_NUM_BITS=285 with the production bitstream.
  - Required: `config_word[284-i]` equals stream bit i for all i, including X positions.
  - `start` pulses while busy have no effect.
